// File: rtl/rr_arbiter_4x2_pkg.sv
// Shared types, constants and reference helpers for the 4-way round-robin arbiter.
package arb_pkg;

    // Requester count is fixed at 4; the index width follows from it.
    localparam int unsigned N_REQ = 4;
    localparam int unsigned IDX_W = 2;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    // Returns {valid, idx}: first set request bit searching ptr, ptr+1, ... (mod N_REQ).
    function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] j;
        res = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            j = ptr + IDX_W'(i);
            if (!res[IDX_W] && req[j]) begin
                res = {1'b1, j};
            end
        end
        return res;
    endfunction

    // Binary index of a one-hot (or zero) vector; zero maps to index 0.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter_4x2_if.sv
// Request/grant bundle between the requesting agents and the arbiter.
interface rr_arbiter_4x2_if;

    logic [arb_pkg::N_REQ-1:0] req;
    logic [arb_pkg::N_REQ-1:0] done;
    logic [arb_pkg::N_REQ-1:0] gnt;
    logic [arb_pkg::IDX_W-1:0] gnt_idx;
    logic                      gnt_valid;
    logic                      timeout;

    // Requester side drives requests and release strobes.
    modport master (
        output req, done,
        input  gnt, gnt_idx, gnt_valid, timeout
    );

    // Arbiter side consumes requests and drives the registered grant.
    modport slave (
        input  req, done,
        output gnt, gnt_idx, gnt_valid, timeout
    );

endinterface

// File: rtl/rr_arbiter_4x2_pick.sv
// Combinational round-robin selector: rotate by ptr, priority-encode, un-rotate.
module rr_pick_4
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [IDX_W-1:0]   off;

    // rot[i] is req[(ptr+i) mod 4], so the lowest set bit is the round-robin winner.
    always_comb begin
        dbl   = {req, req};
        rot   = dbl[ptr +: N_REQ];
        valid = |rot;
        casez (rot)
            4'b???1: off = 2'd0;
            4'b??10: off = 2'd1;
            4'b?100: off = 2'd2;
            4'b1000: off = 2'd3;
            default: off = 2'd0;
        endcase
        idx = ptr + off;
    end

endmodule

// File: rtl/rr_arbiter_4x2.sv
// Round-robin arbiter for 4 requesters with registered one-hot/indexed grant
// and a hold-timeout guard that forces release after MAX_HOLD cycles.
module rr_arbiter_4x2
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16,  // 0 disables the timeout
    parameter int unsigned CNT_W    = 5    // 2**CNT_W must exceed MAX_HOLD
) (
    input  logic             clk,
    input  logic             rst_n,
    rr_arbiter_4x2_if.slave  bus
);

    localparam logic             HOLD_EN  = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_SAT  = HOLD_EN ? HOLD_LIM : '1;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic             timeout_q, timeout_d;

    logic             own_done;
    logic             own_req;
    logic             hold_hit;
    logic             rel;
    logic [N_REQ-1:0] pick_req;
    logic [IDX_W-1:0] pick_ptr;
    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W:0]   pick_ref;

    // Release detection and selector inputs: in GRANT the search starts past the
    // owner, and the owner is masked when it released by done or by timeout.
    always_comb begin
        own_done = bus.done[gnt_idx_q];
        own_req  = bus.req[gnt_idx_q];
        hold_hit = HOLD_EN && (cnt_q == HOLD_LIM);
        rel      = (state_q == GRANT) && (own_done || !own_req || hold_hit);
        pick_req = bus.req;
        pick_ptr = ptr_q;
        if (state_q == GRANT) begin
            pick_ptr = gnt_idx_q + IDX_W'(1);
            if (own_done || hold_hit) begin
                pick_req = bus.req & ~gnt_q;
            end
        end
    end

    rr_pick_4 u_pick (
        .req   (pick_req),
        .ptr   (pick_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Next-state: IDLE grants the winner; GRANT either keeps counting or
    // releases and hands over in the same edge (no idle bubble).
    // timeout flags only a release caused solely by the hold limit.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d     = GRANT;
                    gnt_d       = N_REQ'(1) << pick_idx;
                    gnt_idx_d   = pick_idx;
                    gnt_valid_d = 1'b1;
                    cnt_d       = CNT_W'(1);
                end
            end
            GRANT: begin
                if (rel) begin
                    ptr_d     = gnt_idx_q + IDX_W'(1);
                    timeout_d = hold_hit && !own_done && own_req;
                    if (pick_valid) begin
                        gnt_d       = N_REQ'(1) << pick_idx;
                        gnt_idx_d   = pick_idx;
                        gnt_valid_d = 1'b1;
                        cnt_d       = CNT_W'(1);
                    end else begin
                        state_d     = IDLE;
                        gnt_d       = '0;
                        gnt_idx_d   = '0;
                        gnt_valid_d = 1'b0;
                    end
                end else if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = '0;
                gnt_idx_d   = '0;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    // State, pointer, counter and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = gnt_idx_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.timeout   = timeout_q;

    assign pick_ref = rr_pick(pick_req, pick_ptr);

    a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q))
        else $error("grant not one-hot");
    a_idx: assert property (@(posedge clk) disable iff (!rst_n) gnt_idx_q == onehot_to_idx(gnt_q))
        else $error("grant index does not encode grant");
    a_valid: assert property (@(posedge clk) disable iff (!rst_n) gnt_valid_q == (|gnt_q))
        else $error("grant valid does not match grant");
    a_pick: assert property (@(posedge clk) disable iff (!rst_n)
                             (pick_valid == pick_ref[IDX_W]) &&
                             (!pick_valid || pick_idx == pick_ref[IDX_W-1:0]))
        else $error("selector disagrees with rr_pick");

endmodule

// File: tb/tb_rr_arbiter_4x2.sv
// Scoreboard bench for rr_arbiter_4x2: stimulus pushes model predictions,
// a monitor pops and compares one entry per clock.
module tb_rr_arbiter_4x2;

    localparam int MH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rr_arbiter_4x2_if bus();

    rr_arbiter_4x2 #(.MAX_HOLD(MH), .CNT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       valid;
        logic       to;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: current owner (-1 = none), cycles held, search start.
    int m_owner = -1;
    int m_held  = 0;
    int m_ptr   = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int search(input logic [3:0] r, input int from);
        for (int i = 0; i < 4; i++) begin
            int j;
            j = (from + i) % 4;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_ptr   = 0;
    endtask

    // Drive one cycle of inputs and push the outputs expected after the next edge.
    task automatic drive(input logic [3:0] r, input logic [3:0] d);
        exp_t e;
        bit   to;
        to = 0;
        bus.req  = r;
        bus.done = d;
        if (m_owner < 0) begin
            m_owner = search(r, m_ptr);
            if (m_owner >= 0) m_held = 1;
        end else begin
            int k;
            bit forced;
            logic [3:0] elig;
            k = m_owner;
            forced = (MH != 0) && (m_held == MH);
            if (d[k] || !r[k] || forced) begin
                m_ptr = (k + 1) % 4;
                to = forced && !d[k] && r[k];
                elig = r;
                if (d[k] || forced) elig[k] = 1'b0;
                m_owner = search(elig, m_ptr);
                m_held = 1;
            end else if (m_held < MH) begin
                m_held++;
            end
        end
        e.gnt = '0;
        e.idx = '0;
        e.valid = (m_owner >= 0);
        if (m_owner >= 0) begin
            e.gnt[m_owner] = 1'b1;
            e.idx = 2'(m_owner);
        end
        e.to = to;
        q.push_back(e);
    endtask

    task automatic step(input logic [3:0] r, input logic [3:0] d);
        @(negedge clk);
        drive(r, d);
    endtask

    // Monitor: every cycle the DUT presents a registered result; compare it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("gnt",       int'(bus.gnt),       int'(e.gnt));
                check("gnt_idx",   int'(bus.gnt_idx),   int'(e.idx));
                check("gnt_valid", int'(bus.gnt_valid), int'(e.valid));
                check("timeout",   int'(bus.timeout),   int'(e.to));
            end
        end
    end

    initial begin
        logic [3:0] r;
        logic [3:0] d;

        bus.req  = 4'b1111;
        bus.done = 4'b0000;
        rst_n    = 1'b0;
        model_reset();
        #12;
        check("rst_gnt",     int'(bus.gnt),       0);
        check("rst_valid",   int'(bus.gnt_valid), 0);
        check("rst_idx",     int'(bus.gnt_idx),   0);
        check("rst_timeout", int'(bus.timeout),   0);

        // Release with all requesting: owner 0 one cycle later.
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'b1111, 4'b0000);

        // Fairness: done from each owner in turn.
        step(4'b1111, 4'b0001);
        step(4'b1111, 4'b0010);
        step(4'b1111, 4'b0100);
        step(4'b1111, 4'b1000);
        step(4'b0000, 4'b0000);
        step(4'b0000, 4'b0000);

        // Single requester held three cycles, then done.
        step(4'b0100, 4'b0000);
        step(4'b0100, 4'b0000);
        step(4'b0100, 4'b0000);
        step(4'b0100, 4'b0100);
        step(4'b0000, 4'b0000);

        // Timeout: nobody asserts done.
        for (int i = 0; i < 10; i++) step(4'b0011, 4'b0000);
        step(4'b0000, 4'b0000);
        step(4'b0000, 4'b0000);

        // Mid-grant reset with owner 2.
        step(4'b0100, 4'b0000);
        step(4'b0100, 4'b0000);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_gnt",   int'(bus.gnt),       0);
        check("async_rst_valid", int'(bus.gnt_valid), 0);
        check("async_rst_idx",   int'(bus.gnt_idx),   0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'b0101, 4'b0000);

        // Non-owner strobes ignored; idle strobes ignored.
        step(4'b0010, 4'b0001);
        step(4'b0010, 4'b1101);
        step(4'b0010, 4'b1101);
        step(4'b0010, 4'b0010);
        step(4'b0000, 4'b1111);
        step(4'b0000, 4'b1111);

        // Randomized traffic; requests tend to persist so timeouts occur.
        r = 4'b0000;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            d = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            step(r, d);
        end

        @(posedge clk);
        #3;
        check("drain", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_4x2.md
Name: rr_arbiter_4x2

Overview:
- Round-robin arbiter that shares one downstream resource among 4 requesters.
- Emits a one-hot grant plus a 2-bit encoded grant index with a valid bit, so the encoder's output convention (index + V) becomes a registered, fairly scheduled grant.
- Sits between requesting agents and the shared datapath; the grant index drives the datapath's select mux.
- Grants can be held across cycles, with a hold-timeout guard.

Parameters:
- N_REQ, 4, number of requesters; fixed at 4, present for documentation and asserts only.
- IDX_W, 2, width of the encoded grant index (log2 N_REQ).
- MAX_HOLD, 16, maximum cycles a grant may be held before forced release; 0 disables the timeout.
- CNT_W, 5, hold-counter width; must satisfy 2**CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  request vector; bit i is requester i, level-sensitive.
- done  input  4  release strobe; bit i is honoured only while requester i is granted.
- gnt  output  4  registered one-hot grant; all-zero when idle.
- gnt_idx  output  2  binary index of the granted requester; 0 when gnt_valid=0.
- gnt_valid  output  1  1 while any grant is active; equals |gnt.
- timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - gnt=0000, gnt_idx=00, gnt_valid=0, timeout=0.
  - Priority pointer ptr=0, hold counter=0, state=IDLE.
- State IDLE:
  - If req==0000, stay in IDLE.
  - Otherwise select the first set bit searching ptr, ptr+1, ... (mod 4).
  - The grant appears on the next rising edge, so request-to-grant latency is 1 cycle.
  - Move to GRANT, set counter=1.
- State GRANT (owner k):
  - Outputs hold gnt[k]=1, gnt_idx=k, gnt_valid=1.
  - Counter increments once per cycle and saturates at MAX_HOLD.
- Release conditions in GRANT (evaluated each edge; any one triggers):
  - done[k]=1.
  - req[k]=0.
  - MAX_HOLD!=0 and counter==MAX_HOLD.
- On release:
  - ptr <= k+1 mod 4.
  - Re-arbitrate in the same edge over the current req, using the new pointer, with req[k] masked if done[k] or a timeout caused the release.
  - If any bit wins, grant it on the next cycle with no idle bubble; counter=1.
  - If no bit wins, go to IDLE with gnt=0000.
- Timeout:
  - timeout=1 only in the cycle after a forced release, coincident with the new grant or idle.
  - A requester that timed out may be re-granted only after a full round-robin pass (masked once, then lowest priority).
- done bits of non-owners are ignored. done with gnt_valid=0 is ignored.
- Simultaneous done[k] and a new req[k]: release takes priority; k becomes lowest priority.
- Invariants (assert): gnt is always one-hot or zero; gnt_idx==encode(gnt); gnt_valid==|gnt.
- Pointer wrap: after owner 3, ptr=0.
- Reset asserted mid-grant: all outputs clear immediately (asynchronously); the previous owner has no special priority afterwards.
- No combinational path from req/done to any output; all outputs are registered.

Decomposition:
- Shared package arb_pkg:
  - state enum {IDLE, GRANT}.
  - Constants N_REQ=4, IDX_W=2.
  - Function rr_pick(req, ptr) returning {valid, idx}.
  - Function onehot_to_idx.
- One natural sub-module, rr_pick_4: the combinational rotate-and-priority-encode (rotate req by ptr, priority-encode, un-rotate).
- The top level holds the FSM, pointer, counter and output registers.

Test Plan:
- Reset with req=1111, then release rst_n.
  - Required: gnt=0000 and gnt_valid=0 during reset.
  - One cycle after release: gnt=0001, gnt_idx=00, gnt_valid=1.
- Fairness: req=1111 held, pulse done on each owner.
  - Required: grant sequence 0001 -> 0010 -> 0100 -> 1000 -> 0001.
  - Each handover has no idle cycle between grants.
- Single requester: req=0100 only, done pulsed after 3 cycles.
  - Required: gnt=0100, gnt_idx=10 for 3 cycles, then gnt=0000 and gnt_valid=0 the next cycle.
- Timeout with MAX_HOLD=4: req=0011, owner 0 never asserts done.
  - Required: gnt=0001 for 4 cycles.
  - Then timeout=1 for exactly one cycle, with gnt=0010 that same cycle.
- Mid-grant reset: owner 2 active, assert rst_n=0 between clock edges.
  - Required: outputs clear asynchronously.
  - After release with req=0101: gnt=0001 (pointer reset to 0).
- Ignored strobes: owner 1 active, done=1101 (owner's bit clear), req[1] held.
  - Required: grant unchanged (gnt=0010), timeout=0.
